// File: rtl/logica_simple_exerciser.sv
// Sweep driver for the 3-in/3-out lab circuit: drives all eight A/B/C
// vectors, samples X/Y/Z after a settle time and reports a fail map.
module logica_simple_exerciser #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    input  logic       x_i,
    input  logic       y_i,
    input  logic       z_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vector
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_n;
    logic [2:0] r_vec;
    logic [2:0] w_vec_n;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_n;
    logic [3:0] r_err;
    logic [3:0] w_err_n;
    logic [7:0] r_fail;
    logic [7:0] w_fail_n;
    logic [2:0] r_stim;
    logic [2:0] w_stim_n;
    logic       w_gx;
    logic       w_gy;
    logic       w_gz;
    logic       w_mis;

    // Golden: X = A, Y = -A (equal to A in one bit), Z = B & C.
    assign w_gx  = r_vec[2];
    assign w_gy  = r_vec[2];
    assign w_gz  = r_vec[1] & r_vec[0];
    assign w_mis = (x_i != w_gx) | (y_i != w_gy) | (z_i != w_gz);

    always_comb begin
        w_state_n = r_state;
        w_vec_n   = r_vec;
        w_cnt_n   = r_cnt;
        w_err_n   = r_err;
        w_fail_n  = r_fail;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_vec_n   = 3'd0;
                    w_cnt_n   = 4'd0;
                    w_err_n   = 4'd0;
                    w_fail_n  = 8'd0;
                    w_state_n = SETTLE;
                end
            end
            SETTLE: begin
                w_cnt_n = r_cnt + 4'd1;
                if (r_cnt == LP_LAST) begin
                    w_state_n = CHECK;
                end
            end
            CHECK: begin
                if (w_mis) begin
                    w_fail_n[r_vec] = 1'b1;
                    w_err_n         = r_err + 4'd1;
                end
                if (r_vec == 3'd7) begin
                    w_state_n = DONE;
                end else begin
                    w_vec_n   = r_vec + 3'd1;
                    w_cnt_n   = 4'd0;
                    w_state_n = SETTLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // Stimulus is registered from the next-state view so pins never glitch.
    always_comb begin
        w_stim_n = 3'd0;
        if (w_state_n == SETTLE || w_state_n == CHECK) begin
            w_stim_n = w_vec_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_vec   <= 3'd0;
            r_cnt   <= 4'd0;
            r_err   <= 4'd0;
            r_fail  <= 8'd0;
            r_stim  <= 3'd0;
        end else begin
            r_state <= w_state_n;
            r_vec   <= w_vec_n;
            r_cnt   <= w_cnt_n;
            r_err   <= w_err_n;
            r_fail  <= w_fail_n;
            r_stim  <= w_stim_n;
        end
    end

    assign a_o         = r_stim[2];
    assign b_o         = r_stim[1];
    assign c_o         = r_stim[0];
    assign busy        = (r_state == SETTLE) || (r_state == CHECK);
    assign done        = (r_state == DONE);
    assign pass        = (r_state == DONE) && (r_err == 4'd0);
    assign err_count   = r_err;
    assign fail_vector = r_fail;

endmodule
